// File: rtl/ltssm_ts_rx_decoder_pkg.sv
// Shared constants and types for the per-lane TS1/TS2 receive decoder.
package ltssm_ts_rx_decoder_pkg;

    localparam logic [7:0] COM    = 8'hBC;
    localparam logic [7:0] PAD    = 8'hF7;
    localparam logic [7:0] TS1_ID = 8'h4A;
    localparam logic [7:0] TS2_ID = 8'h45;

    // Beat position within the 4-beat ordered set; HUNT waits for the COM beat.
    typedef enum logic [1:0] {
        ST_HUNT,
        ST_B1,
        ST_B2,
        ST_B3
    } ts_rx_st_e;

    // Training control symbol (symbol 5), bit 0 = hot reset.
    typedef struct packed {
        logic [2:0] rsvd;
        logic       compliance_rx;
        logic       disable_scrambling;
        logic       loopback;
        logic       disable_link;
        logic       hot_reset;
    } training_ctrl_t;

    // Link/lane number symbols may carry K only when they are PAD.
    function automatic logic num_sym_ok(input logic [7:0] s, input logic k);
        return !k || (s == PAD);
    endfunction

    // True when all four symbols of a beat equal the given ID.
    function automatic logic beat_all_eq(input logic [31:0] d, input logic [7:0] v);
        return (d[7:0] == v) && (d[15:8] == v) && (d[23:16] == v) && (d[31:24] == v);
    endfunction

endpackage

// File: rtl/ltssm_ts_rx_decoder.sv
// Per-lane TS1/TS2 ordered-set parser: checks symbol legality beat by beat,
// publishes captured fields on a good TS and counts identical back-to-back TSs.
module ltssm_ts_rx_decoder
    import ltssm_ts_rx_decoder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [KEEP_WIDTH-1:0] s_axis_tk,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  ts1_valid_o,
    output logic                  ts2_valid_o,
    output logic [7:0]            link_num_o,
    output logic [7:0]            lane_num_o,
    output logic [7:0]            n_fts_o,
    output logic [7:0]            rate_id_o,
    output training_ctrl_t        training_ctrl_o,
    output logic [CNT_WIDTH-1:0]  consec_cnt_o,
    output logic                  error_o
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("ltssm_ts_rx_decoder supports DATA_WIDTH=32 only");
    end

    assign s_axis_tready = 1'b1;

    ts_rx_st_e          st_q, st_d;
    logic [7:0]         p_link_q, p_link_d;
    logic [7:0]         p_lane_q, p_lane_d;
    logic [7:0]         p_nfts_q, p_nfts_d;
    logic [7:0]         p_rate_q, p_rate_d;
    logic [7:0]         p_ctrl_q, p_ctrl_d;
    logic [7:0]         id_q, id_d;
    logic               prev_vld_q, prev_vld_d;
    logic               prev_ts2_q, prev_ts2_d;
    logic               ts1_d, ts2_d, err_d;
    logic [7:0]         link_d, lane_d, nfts_d, rate_d;
    training_ctrl_t     ctrl_d;
    logic [CNT_WIDTH-1:0] cnt_d;

    logic       keep_ok;
    logic       k_none;
    logic [7:0] sym0, sym1, sym2, sym3;
    logic       same_as_prev;
    logic       cur_ts2;

    assign keep_ok = (s_axis_tkeep == {KEEP_WIDTH{1'b1}});
    assign k_none  = (s_axis_tk == '0);
    assign sym0    = s_axis_tdata[7:0];
    assign sym1    = s_axis_tdata[15:8];
    assign sym2    = s_axis_tdata[23:16];
    assign sym3    = s_axis_tdata[31:24];
    assign cur_ts2 = (id_q == TS2_ID);

    // Symbols 6..15 are forced equal to the ID, so comparing sym1..5 plus type covers 1..15.
    assign same_as_prev = prev_vld_q && (prev_ts2_q == cur_ts2) &&
                          (link_num_o == p_link_q) && (lane_num_o == p_lane_q) &&
                          (n_fts_o == p_nfts_q) && (rate_id_o == p_rate_q) &&
                          (training_ctrl_o == training_ctrl_t'(p_ctrl_q));

    // Next-state: beat checking, field capture, publish and flush handling.
    always_comb begin
        st_d       = st_q;
        p_link_d   = p_link_q;
        p_lane_d   = p_lane_q;
        p_nfts_d   = p_nfts_q;
        p_rate_d   = p_rate_q;
        p_ctrl_d   = p_ctrl_q;
        id_d       = id_q;
        prev_vld_d = prev_vld_q;
        prev_ts2_d = prev_ts2_q;
        ts1_d      = 1'b0;
        ts2_d      = 1'b0;
        err_d      = 1'b0;
        link_d     = link_num_o;
        lane_d     = lane_num_o;
        nfts_d     = n_fts_o;
        rate_d     = rate_id_o;
        ctrl_d     = training_ctrl_o;
        cnt_d      = consec_cnt_o;
        if (flush_i) begin
            st_d       = ST_HUNT;
            cnt_d      = '0;
            prev_vld_d = 1'b0;
        end else if (s_axis_tvalid) begin
            case (st_q)
                ST_HUNT: begin
                    if (s_axis_tk[0] && sym0 == COM && keep_ok && !s_axis_tlast) begin
                        if (num_sym_ok(sym1, s_axis_tk[1]) && num_sym_ok(sym2, s_axis_tk[2]) &&
                            !s_axis_tk[3]) begin
                            p_link_d = sym1;
                            p_lane_d = sym2;
                            p_nfts_d = sym3;
                            st_d     = ST_B1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_B1: begin
                    if (keep_ok && !s_axis_tlast && k_none && (sym3 == sym2) &&
                        (sym2 == TS1_ID || sym2 == TS2_ID)) begin
                        p_rate_d = sym0;
                        p_ctrl_d = sym1;
                        id_d     = sym2;
                        st_d     = ST_B2;
                    end else begin
                        err_d = 1'b1;
                        st_d  = ST_HUNT;
                    end
                end
                ST_B2: begin
                    if (keep_ok && !s_axis_tlast && k_none && beat_all_eq(s_axis_tdata, id_q)) begin
                        st_d = ST_B3;
                    end else begin
                        err_d = 1'b1;
                        st_d  = ST_HUNT;
                    end
                end
                default: begin
                    st_d = ST_HUNT;
                    if (keep_ok && s_axis_tlast && k_none && beat_all_eq(s_axis_tdata, id_q)) begin
                        ts1_d      = !cur_ts2;
                        ts2_d      = cur_ts2;
                        link_d     = p_link_q;
                        lane_d     = p_lane_q;
                        nfts_d     = p_nfts_q;
                        rate_d     = p_rate_q;
                        ctrl_d     = training_ctrl_t'(p_ctrl_q);
                        prev_vld_d = 1'b1;
                        prev_ts2_d = cur_ts2;
                        if (same_as_prev)
                            cnt_d = (consec_cnt_o == '1) ? consec_cnt_o : consec_cnt_o + CNT_WIDTH'(1);
                        else
                            cnt_d = CNT_WIDTH'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // State, pending fields and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q            <= ST_HUNT;
            p_link_q        <= '0;
            p_lane_q        <= '0;
            p_nfts_q        <= '0;
            p_rate_q        <= '0;
            p_ctrl_q        <= '0;
            id_q            <= '0;
            prev_vld_q      <= 1'b0;
            prev_ts2_q      <= 1'b0;
            ts1_valid_o     <= 1'b0;
            ts2_valid_o     <= 1'b0;
            error_o         <= 1'b0;
            link_num_o      <= '0;
            lane_num_o      <= '0;
            n_fts_o         <= '0;
            rate_id_o       <= '0;
            training_ctrl_o <= '0;
            consec_cnt_o    <= '0;
        end else begin
            st_q            <= st_d;
            p_link_q        <= p_link_d;
            p_lane_q        <= p_lane_d;
            p_nfts_q        <= p_nfts_d;
            p_rate_q        <= p_rate_d;
            p_ctrl_q        <= p_ctrl_d;
            id_q            <= id_d;
            prev_vld_q      <= prev_vld_d;
            prev_ts2_q      <= prev_ts2_d;
            ts1_valid_o     <= ts1_d;
            ts2_valid_o     <= ts2_d;
            error_o         <= err_d;
            link_num_o      <= link_d;
            lane_num_o      <= lane_d;
            n_fts_o         <= nfts_d;
            rate_id_o       <= rate_d;
            training_ctrl_o <= ctrl_d;
            consec_cnt_o    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ltssm_ts_rx_decoder.sv
// Scoreboard bench for ltssm_ts_rx_decoder: a reference model pushes expected
// pulses (kind, fields, count, cycle) as TSs are driven; outputs are popped and compared.
module tb_ltssm_ts_rx_decoder;
    import ltssm_ts_rx_decoder_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           flush = 1'b0;
    logic [31:0]    tdata = '0;
    logic [3:0]     tkeep = '0;
    logic [3:0]     tk = '0;
    logic           tvalid = 1'b0;
    logic           tlast = 1'b0;
    logic           tready;
    logic           ts1_v, ts2_v, err;
    logic [7:0]     link, lane, nfts, rate, cnt;
    training_ctrl_t ctrl;

    ltssm_ts_rx_decoder #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .CNT_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tk(tk),
        .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .s_axis_tready(tready),
        .ts1_valid_o(ts1_v), .ts2_valid_o(ts2_v),
        .link_num_o(link), .lane_num_o(lane), .n_fts_o(nfts), .rate_id_o(rate),
        .training_ctrl_o(ctrl), .consec_cnt_o(cnt), .error_o(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;   // 1 = TS1, 2 = TS2, 3 = error
        logic [7:0] link, lane, nfts, rate, ctrl, cnt;
        int         cyc;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // reference model of the last good TS
    logic       m_vld = 1'b0;
    logic [7:0] m_link = 0, m_lane = 0, m_nfts = 0, m_rate = 0, m_ctrl = 0, m_id = 0;
    logic [7:0] m_cnt = 0;

    task automatic monitor();
        exp_t e;
        int   k;
        if (rst) return;
        if (!(ts1_v || ts2_v || err)) return;
        n_checks++;
        k = (int'(ts1_v) + int'(ts2_v) + int'(err) > 1) ? 4 : ts1_v ? 1 : ts2_v ? 2 : 3;
        if (q.size() == 0) begin
            $display("FAIL unexpected_pulse: kind=%0d at cyc=%0d, required no pulse", k, cyc);
            return;
        end
        e = q.pop_front();
        if (k !== e.kind || link !== e.link || lane !== e.lane || nfts !== e.nfts ||
            rate !== e.rate || ctrl !== e.ctrl || cnt !== e.cnt || cyc !== e.cyc)
            $display("FAIL pulse: got kind=%0d link=%h lane=%h nfts=%h rate=%h ctrl=%h cnt=%0d cyc=%0d; required kind=%0d link=%h lane=%h nfts=%h rate=%h ctrl=%h cnt=%0d cyc=%0d",
                     k, link, lane, nfts, rate, ctrl, cnt, cyc,
                     e.kind, e.link, e.lane, e.nfts, e.rate, e.ctrl, e.cnt, e.cyc);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            tvalid = 1'b0; tlast = 1'b0; flush = 1'b0;
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic [3:0] keep,
                        input logic last, input logic fl, output int c);
        tick();
        tdata = d; tk = k; tkeep = keep; tlast = last; tvalid = 1'b1; flush = fl;
        c = cyc;
    endtask

    task automatic push(input int kind, input int c);
        exp_t e;
        e.kind = kind; e.link = m_link; e.lane = m_lane; e.nfts = m_nfts;
        e.rate = m_rate; e.ctrl = m_ctrl; e.cnt = m_cnt; e.cyc = c + 1;
        q.push_back(e);
    endtask

    // mode: 0 good, 1 wrong ID in sym9, 2 tlast on beat2, 3 no tlast on beat3,
    //       4 flush on beat3, 5 stop after beat1
    task automatic send_ts(input logic [7:0] l, input logic lk, input logic [7:0] n, input logic nk,
                           input logic [7:0] f, input logic [7:0] r, input logic [7:0] t,
                           input logic [7:0] id, input int gapmax, input int mode);
        logic [7:0] s [16];
        logic       last;
        logic       same;
        int         c;
        s[0] = COM; s[1] = l; s[2] = n; s[3] = f; s[4] = r; s[5] = t;
        for (int i = 6; i < 16; i++) s[i] = id;
        if (mode == 1) s[9] = (id == TS1_ID) ? TS2_ID : TS1_ID;
        for (int b = 0; b < 4; b++) begin
            if (b > 0 && gapmax > 0) idle($urandom_range(0, gapmax));
            last = (mode == 2) ? (b == 2) : (mode == 3) ? 1'b0 : (b == 3);
            beat({s[4*b+3], s[4*b+2], s[4*b+1], s[4*b]},
                 (b == 0) ? {1'b0, nk, lk, 1'b1} : 4'h0, 4'hF, last,
                 (mode == 4) && (b == 3), c);
            if (mode == 5 && b == 1) return;
            if ((mode == 1 || mode == 2) && b == 2) begin
                push(3, c);
                return;
            end
        end
        if (mode == 3) begin
            push(3, c);
        end else if (mode == 4) begin
            m_vld = 1'b0; m_cnt = 0;
        end else begin
            same = m_vld && m_link == l && m_lane == n && m_nfts == f && m_rate == r &&
                   m_ctrl == t && m_id == id;
            m_cnt = !same ? 8'd1 : (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1;
            m_vld = 1'b1; m_link = l; m_lane = n; m_nfts = f; m_rate = r; m_ctrl = t; m_id = id;
            push((id == TS1_ID) ? 1 : 2, c);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ts1_v, ts2_v, err, link, lane, nfts, rate, ctrl, cnt} !== '0)
            $display("FAIL reset_outputs: got %h, required 0",
                     {ts1_v, ts2_v, err, link, lane, nfts, rate, ctrl, cnt});
        else n_pass++;
        n_checks++;
        if (tready !== 1'b1) $display("FAIL reset_tready: got %b, required 1", tready);
        else n_pass++;
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_ts1_basic();
        send_ts(PAD, 1'b1, PAD, 1'b1, 8'h20, 8'h02, 8'h00, TS1_ID, 0, 0);
        idle(2);
        n_checks++;
        if (link !== 8'hF7 || cnt !== 8'd1)
            $display("FAIL ts1_basic_hold: link=%h cnt=%0d, required link=f7 cnt=1", link, cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++)
            send_ts(8'h01, 1'b0, 8'h00, 1'b0, 8'h20, 8'h02, 8'h00, TS2_ID, 0, 0);
        send_ts(8'h01, 1'b0, 8'h03, 1'b0, 8'h20, 8'h02, 8'h00, TS2_ID, 0, 0);
        idle(2);
        n_checks++;
        if (cnt !== 8'd1) $display("FAIL b2b_lane_change_cnt: got %0d, required 1", cnt);
        else n_pass++;
    endtask

    task automatic test_bad_id();
        send_ts(8'h01, 1'b0, 8'h03, 1'b0, 8'h20, 8'h02, 8'h00, TS1_ID, 0, 1);
        send_ts(8'h01, 1'b0, 8'h03, 1'b0, 8'h20, 8'h02, 8'h00, TS1_ID, 0, 0);
        idle(2);
    endtask

    task automatic test_tlast_errors();
        int c;
        beat(32'h4A4A4A4A, 4'h0, 4'hF, 1'b0, 1'b0, c);  // non-COM beat in hunt: silent
        send_ts(8'h05, 1'b0, 8'h06, 1'b0, 8'h10, 8'h01, 8'h00, TS1_ID, 0, 2);
        send_ts(8'h05, 1'b0, 8'h06, 1'b0, 8'h10, 8'h01, 8'h00, TS1_ID, 0, 0);
        send_ts(8'h05, 1'b0, 8'h06, 1'b0, 8'h10, 8'h01, 8'h00, TS1_ID, 0, 3);
        send_ts(8'h05, 1'b0, 8'h06, 1'b0, 8'h10, 8'h01, 8'h00, TS1_ID, 0, 0);
        idle(2);
    endtask

    task automatic test_random_gaps();
        logic [7:0] l, t;
        logic [7:0] id;
        for (int i = 0; i < 6; i++) begin
            l  = 8'($urandom_range(0, 31));
            t  = 8'($urandom_range(0, 31));
            id = ($urandom_range(0, 1) == 1) ? TS2_ID : TS1_ID;
            repeat (2) send_ts(l, 1'b0, 8'h01, 1'b0, 8'h30, 8'h02, t, id, 3, 0);
        end
        idle(2);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 258; i++)
            send_ts(8'h02, 1'b0, 8'h02, 1'b0, 8'h40, 8'h02, 8'h01, TS1_ID, 0, 0);
        idle(2);
        n_checks++;
        if (cnt !== 8'hFF) $display("FAIL saturation_cnt: got %0d, required 255", cnt);
        else n_pass++;
    endtask

    task automatic test_flush();
        send_ts(8'h07, 1'b0, 8'h01, 1'b0, 8'h40, 8'h02, 8'h00, TS2_ID, 0, 0);
        send_ts(8'h07, 1'b0, 8'h01, 1'b0, 8'h40, 8'h02, 8'h00, TS2_ID, 0, 4);
        idle(2);
        n_checks++;
        if (cnt !== 8'd0) $display("FAIL flush_cnt: got %0d, required 0", cnt);
        else n_pass++;
        send_ts(8'h07, 1'b0, 8'h01, 1'b0, 8'h40, 8'h02, 8'h00, TS2_ID, 0, 0);
        idle(2);
    endtask

    task automatic test_async_reset();
        send_ts(8'h09, 1'b0, 8'h01, 1'b0, 8'h40, 8'h02, 8'h00, TS1_ID, 0, 5);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({ts1_v, ts2_v, err, link, lane, nfts, rate, ctrl, cnt} !== '0 || tready !== 1'b1)
            $display("FAIL async_reset_outputs: got %h tready=%b, required 0 tready=1",
                     {ts1_v, ts2_v, err, link, lane, nfts, rate, ctrl, cnt}, tready);
        else n_pass++;
        tvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_vld = 1'b0; m_cnt = 0; m_link = 0; m_lane = 0; m_nfts = 0; m_rate = 0; m_ctrl = 0;
        send_ts(8'h09, 1'b0, 8'h01, 1'b0, 8'h40, 8'h02, 8'h00, TS1_ID, 0, 0);
        idle(3);
    endtask

    initial begin
        test_reset();
        test_ts1_basic();
        test_back_to_back();
        test_bad_id();
        test_tlast_errors();
        test_random_gaps();
        test_saturation();
        test_flush();
        test_async_reset();
        idle(4);
        n_checks++;
        if (q.size() != 0) $display("FAIL missing_pulses: %0d outstanding, required 0", q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
